// File: rtl/pipeline_sequencer_pkg.sv
// Shared types and constants for the pipeline sequencer.
// State encodings, drain length and register-zero id.
package pipeline_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_DRAIN,
    ST_HALTED
  } state_e;

  localparam logic [1:0] DRAIN_CYCLES = 2'd3;
  localparam logic [4:0] REG_ZERO     = 5'd0;

  typedef struct packed {
    logic pipe_en;
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_flush;
  } ctrl_t;

endpackage

// File: rtl/pipeline_sequencer_load_use_detector.sv
// Load-use hazard compare between EX load and ID sources.
// Register zero never creates a dependency.
module load_use_detector
  import pipeline_sequencer_pkg::*;
(
  input  logic       ex_load,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       stall
);

  assign stall = ex_load
               & (ex_rt != REG_ZERO)
               & ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_sequencer.sv
// Run/step/drain sequencer with load-use stall and halt drain.
// Outputs decode combinationally from state and ID/EX inputs.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_run,
  input  logic        i_step,
  input  logic [4:0]  i_id_rs,
  input  logic [4:0]  i_id_rt,
  input  logic        i_id_halt,
  input  logic        i_id_branch_taken,
  input  logic        i_ex_load,
  input  logic [4:0]  i_ex_rt,
  output logic        o_pipe_en,
  output logic        o_pc_we,
  output logic        o_ifid_we,
  output logic        o_ifid_flush,
  output logic        o_idex_flush,
  output logic        o_halted,
  output logic        o_busy,
  output logic [31:0] o_cycle_cnt
);

  state_e      state_q, state_d;
  logic [1:0]  drain_q, drain_d;
  logic [31:0] cnt_q;
  logic        raw_stall;
  logic        active;
  logic        stall;
  logic        halt_det;
  logic        br_go;
  logic        flow_go;
  ctrl_t       ctrl;

  load_use_detector u_lud (
    .ex_load (i_ex_load),
    .ex_rt   (i_ex_rt),
    .id_rs   (i_id_rs),
    .id_rt   (i_id_rt),
    .stall   (raw_stall)
  );

  assign active   = (state_q == ST_RUN) | (state_q == ST_STEP);
  assign stall    = active & raw_stall;
  assign halt_det = active & i_id_halt & ~raw_stall;
  assign br_go    = active & ~raw_stall & ~i_id_halt
                  & i_id_branch_taken;
  assign flow_go  = active & ~raw_stall & ~i_id_halt
                  & ~i_id_branch_taken;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      drain_q <= 2'd0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (ctrl.pipe_en && cnt_q != 32'hFFFF_FFFF)
        cnt_q <= cnt_q + 32'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_run)       state_d = ST_RUN;
        else if (i_step) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (halt_det) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_CYCLES;
        end
      end
      ST_STEP: begin
        if (halt_det) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_CYCLES;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q - 2'd1;
        if (drain_q == 2'd1) state_d = ST_HALTED;
      end
      ST_HALTED: ;
      default: state_d = ST_IDLE;
    endcase
  end

  // Terms are mutually exclusive; stall already masks halt and branch.
  always_comb begin
    ctrl = '0;
    unique case (1'b1)
      stall:    ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      halt_det: ctrl = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      br_go:    ctrl = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      flow_go:  ctrl = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      (state_q == ST_DRAIN):
                ctrl = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      default:  ctrl = '0;
    endcase
  end

  assign o_pipe_en    = ctrl.pipe_en;
  assign o_pc_we      = ctrl.pc_we;
  assign o_ifid_we    = ctrl.ifid_we;
  assign o_ifid_flush = ctrl.ifid_flush;
  assign o_idex_flush = ctrl.idex_flush;
  assign o_halted     = (state_q == ST_HALTED);
  assign o_busy       = active | (state_q == ST_DRAIN);
  assign o_cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer.
// Inputs change 1ns after posedge; outputs checked 1ns later.
module tb_pipeline_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [4:0]  id_rs = 5'd0;
  logic [4:0]  id_rt = 5'd0;
  logic        id_halt = 1'b0;
  logic        br = 1'b0;
  logic        ex_load = 1'b0;
  logic [4:0]  ex_rt = 5'd0;
  logic        pipe_en, pc_we, ifid_we;
  logic        ifid_flush, idex_flush;
  logic        halted, busy;
  logic [31:0] cyc;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_sequencer dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_run             (run),
    .i_step            (step),
    .i_id_rs           (id_rs),
    .i_id_rt           (id_rt),
    .i_id_halt         (id_halt),
    .i_id_branch_taken (br),
    .i_ex_load         (ex_load),
    .i_ex_rt           (ex_rt),
    .o_pipe_en         (pipe_en),
    .o_pc_we           (pc_we),
    .o_ifid_we         (ifid_we),
    .o_ifid_flush      (ifid_flush),
    .o_idex_flush      (idex_flush),
    .o_halted          (halted),
    .o_busy            (busy),
    .o_cycle_cnt       (cyc)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // ctrl bundle: pipe_en,pc_we,ifid_we,ifid_flush,idex_flush
  function automatic logic [31:0] ctl();
    return {27'd0, pipe_en, pc_we, ifid_we, ifid_flush, idex_flush};
  endfunction

  initial begin
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check("rst_ctl", ctl(), 32'b00000);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_halt", {31'd0, halted}, 32'd0);
    check("rst_cnt", cyc, 32'd0);

    run = 1'b1;
    settle();
    check("idle_ctl", ctl(), 32'b00000);
    tick();
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      settle();
      check("run_busy", {31'd0, busy}, 32'd1);
      check("run_ctl", ctl(), 32'b11100);
      tick();
    end
    check("run_cnt10", cyc, 32'd10);

    ex_load = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    settle();
    check("stall_rs", ctl(), 32'b10001);
    id_halt = 1'b1; br = 1'b1;
    settle();
    check("stall_prio", ctl(), 32'b10001);
    id_halt = 1'b0; br = 1'b0;
    id_rs = 5'd3; id_rt = 5'd5;
    settle();
    check("stall_rt", ctl(), 32'b10001);
    ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    settle();
    check("no_stall_r0", ctl(), 32'b11100);
    ex_load = 1'b0; ex_rt = 5'd5; id_rs = 5'd5;
    settle();
    check("no_stall_ld0", ctl(), 32'b11100);
    br = 1'b1;
    settle();
    check("branch", ctl(), 32'b11110);
    br = 1'b0; ex_rt = 5'd0; id_rs = 5'd0;

    id_halt = 1'b1;
    settle();
    check("halt_ctl", ctl(), 32'b10011);
    tick();
    id_halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run = 1'b1; step = 1'b1;
      settle();
      check("drain_ctl", ctl(), 32'b10011);
      check("drain_halt", {31'd0, halted}, 32'd0);
      tick();
    end
    run = 1'b0; step = 1'b0;
    check("halted", {31'd0, halted}, 32'd1);
    check("halted_ctl", ctl(), 32'b00000);
    check("halt_cnt", cyc, 32'd14);
    run = 1'b1;
    tick();
    tick();
    run = 1'b0;
    check("halt_hold", {31'd0, halted}, 32'd1);
    check("halt_cnt_hold", cyc, 32'd14);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      settle();
      check("step_idle", ctl(), 32'b00000);
      tick();
      step = (i == 1);
      settle();
      check("step_en", ctl(), 32'b11100);
      tick();
      step = 1'b0;
    end
    settle();
    check("step_back", {31'd0, pipe_en}, 32'd0);
    check("step_cnt3", cyc, 32'd3);
    tick();
    check("step_hold", cyc, 32'd3);

    run = 1'b1; step = 1'b1;
    tick();
    run = 1'b0; step = 1'b0;
    tick();
    check("both_run", {31'd0, busy}, 32'd1);
    check("both_en", ctl(), 32'b11100);

    id_halt = 1'b1;
    tick();
    id_halt = 1'b0;
    tick();
    rst = 1'b1; run = 1'b1;
    settle();
    check("drain2", ctl(), 32'b10011);
    tick();
    rst = 1'b0; run = 1'b0;
    check("mid_rst_en", {31'd0, pipe_en}, 32'd0);
    check("mid_rst_cnt", cyc, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("mid_rst_halt", {31'd0, halted}, 32'd0);
      tick();
    end

    step = 1'b1;
    tick();
    step = 1'b0;
    id_halt = 1'b1;
    settle();
    check("step_halt", ctl(), 32'b10011);
    tick();
    id_halt = 1'b0;
    check("step_drain", {31'd0, busy}, 32'd1);
    tick();
    tick();
    tick();
    check("step_halted", {31'd0, halted}, 32'd1);
    check("step_h_cnt", cyc, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, with the ports listed below, clock and reset first.
REQ-002 i_clk  in  1  rising-edge clock, sole clock.
REQ-003 i_rst  in  1  synchronous active-high reset.
REQ-004 i_run  in  1  one-cycle pulse: start continuous execution.
REQ-005 i_step  in  1  one-cycle pulse: advance pipeline one cycle.
REQ-006 i_id_rs, i_id_rt  in  5 each  source registers of instruction in ID.
REQ-007 i_id_halt  in  1  decoder halt flag for instruction in ID.
REQ-008 i_id_branch_taken  in  1  jump/branch in ID resolved taken.
REQ-009 i_ex_load  in  1  instruction in EX is a load (mem op, type load).
REQ-010 i_ex_rt  in  5  load destination register of instruction in EX.
REQ-011 o_pipe_en  out  1  global enable; EX/MEM and MEM/WB latch only when 1.
REQ-012 o_pc_we, o_ifid_we  out  1 each  PC / IF-ID register write enables.
REQ-013 o_ifid_flush, o_idex_flush  out  1 each  load bubble (all-zero) into IF/ID / ID/EX.
REQ-014 o_halted  out  1  pipeline drained after HALT.
REQ-015 o_busy  out  1  state is RUN, STEP or DRAIN.
REQ-016 o_cycle_cnt  out  32  count of enabled cycles.

Function
REQ-017 The module SHALL implement states IDLE, RUN, STEP, DRAIN, HALTED.
REQ-018 IDLE: i_run -> RUN; else i_step -> STEP; else stay; i_run wins if both are asserted.
REQ-019 RUN: stay until halt detection (REQ-024), then -> DRAIN; i_run/i_step ignored.
REQ-020 STEP: lasts exactly one cycle, then -> IDLE, or -> DRAIN if halt is detected in that cycle; pulses arriving in STEP are ignored, not queued.
REQ-021 o_pipe_en SHALL be 1 in RUN, STEP, DRAIN and 0 in IDLE, HALTED; when o_pipe_en = 0 all other control outputs SHALL be 0.
REQ-022 Stall = i_ex_load & (i_ex_rt != 0) & (i_ex_rt == i_id_rs | i_ex_rt == i_id_rt), evaluated in RUN/STEP only.
REQ-023 On stall: o_pc_we = 0, o_ifid_we = 0, o_idex_flush = 1, o_ifid_flush = 0; stall takes priority over branch and halt in the same cycle.
REQ-024 Halt detection = i_id_halt & ~stall in RUN/STEP: o_pc_we = 0, o_ifid_we = 0, o_ifid_flush = 1, o_idex_flush = 1 (HALT never enters EX), next state DRAIN, drain counter loaded with 3.
REQ-025 Branch taken (no stall, no halt): o_pc_we = 1, o_ifid_we = 1, o_ifid_flush = 1, o_idex_flush = 0.
REQ-026 Otherwise in RUN/STEP: o_pc_we = 1, o_ifid_we = 1, both flushes 0.
REQ-027 DRAIN: o_pc_we = 0, o_ifid_we = 0, o_ifid_flush = 1, o_idex_flush = 1; counter decrements each cycle; on the cycle it reads 1 -> HALTED; DRAIN free-runs regardless of step mode; i_run/i_step are ignored.
REQ-028 HALTED: o_halted = 1, held until reset; all inputs ignored.
REQ-029 o_cycle_cnt SHALL increment by 1 on every cycle with o_pipe_en = 1, saturate at 32'hFFFFFFFF, and hold otherwise.
REQ-030 All outputs SHALL be registered-state derived combinationally from state and inputs, with no input-to-state latency beyond one clock.

Reset
REQ-031 i_rst SHALL, at the next rising edge, force state IDLE, drain counter 0, o_cycle_cnt 0, and therefore o_halted = 0, o_busy = 0, o_pipe_en = 0 and all enables/flushes 0.
REQ-032 Reset SHALL override every state, including mid-DRAIN and HALTED, and SHALL take priority over a simultaneous i_run or i_step.

Structure
REQ-033 State encodings, DRAIN_CYCLES = 3 and REG_ZERO = 5'd0 SHALL live in the shared project header.
REQ-034 The load-use comparison SHALL be a sub-module, load_use_detector (combinational, output stall).

Verification
REQ-035 Reset, then i_run pulse, with no hazards for 10 cycles -> o_busy = 1, o_pc_we = 1 each cycle, o_cycle_cnt = 10.
REQ-036 RUN, i_ex_load = 1, i_ex_rt = 5, i_id_rs = 5 -> the same cycle shows o_pc_we = 0, o_ifid_we = 0, o_idex_flush = 1; i_ex_rt = 0 with i_id_rs = 0 -> no stall.
REQ-037 RUN, i_id_halt = 1 at cycle N -> flushes asserted in cycles N..N+3, o_halted = 1 from N+4, o_cycle_cnt frozen at N+3 cycles.
REQ-038 IDLE, three i_step pulses two cycles apart -> o_pipe_en high exactly 3 cycles and o_cycle_cnt = 3; i_step and i_run asserted together -> RUN.
REQ-039 i_rst asserted in the 2nd DRAIN cycle -> next cycle IDLE, o_cycle_cnt = 0, o_halted never asserted.
